// File: rtl/mem_ctrl.sv
// Byte-wide system memory bus initiator: splits one 1/2/4-byte load or store into
// little-endian byte accesses, tolerating rdy_in pauses and the IO write throttle.
module mem_ctrl #(
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        io_buffer_full,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din
);

   // state   | meaning
   // S_IDLE  | waiting for a request; rsp_valid pulses in the entry cycle
   // S_READ  | driving load bytes onto the bus
   // S_WRITE | driving store bytes onto the bus
   // S_DRAIN | capturing the last load byte one cycle after its issue
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q;
   logic [1:0]  last_q;
   logic [1:0]  next_cnt;
   logic [31:0] wdata_q;
   logic [23:0] rbuf_q;
   logic        rd_iss_q;
   logic [1:0]  rd_idx_q;
   logic        wr_reg_q;
   logic        io_addr;
   logic        io_block;
   logic        issue;
   logic        accept;
   logic        is_last;
   logic [31:0] rd_word;

   assign io_addr   = (mem_a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
   assign io_block  = wr_reg_q & io_addr & io_buffer_full;
   assign mem_wr    = wr_reg_q & ~io_block;
   assign req_ready = (state_q == S_IDLE);
   assign accept    = req_valid & req_ready;
   assign issue     = ((state_q == S_READ) || (state_q == S_WRITE)) && rdy_in && !io_block;
   assign is_last   = (cnt_q == last_q);
   assign next_cnt  = cnt_q + 2'd1;

   // Bytes beyond the request length stay zero because rbuf_q is cleared at accept.
   always_comb begin
      rd_word = {8'h00, rbuf_q};
      rd_word[{rd_idx_q, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = req_wr ? S_WRITE : S_READ;
         S_READ:  if (issue && is_last) state_d = S_DRAIN;
         S_WRITE: if (issue && is_last) state_d = S_IDLE;
         S_DRAIN: if (rd_iss_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q     <= 2'd0;
         last_q    <= 2'd0;
         wdata_q   <= 32'h0;
         rbuf_q    <= 24'h0;
         rd_iss_q  <= 1'b0;
         rd_idx_q  <= 2'd0;
         wr_reg_q  <= 1'b0;
         mem_a     <= 32'h0;
         mem_dout  <= 8'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;
         rd_iss_q  <= (state_q == S_READ) && issue;
         rd_idx_q  <= cnt_q;

         // Capture is keyed only on the previous cycle's issue; rdy_in now is irrelevant.
         if (rd_iss_q) begin
            rbuf_q <= rd_word[23:0];
            if (state_q == S_DRAIN) begin
               rsp_rdata <= rd_word;
               rsp_valid <= 1'b1;
            end
         end

         if (accept) begin
            mem_a    <= req_addr;
            wdata_q  <= req_wdata;
            mem_dout <= req_wdata[7:0];
            wr_reg_q <= req_wr;
            cnt_q    <= 2'd0;
            last_q   <= (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
            rbuf_q   <= 24'h0;
         end else if (issue) begin
            if (is_last) begin
               wr_reg_q <= 1'b0;
               if (state_q == S_WRITE) rsp_valid <= 1'b1;
            end else begin
               cnt_q    <= next_cnt;
               mem_a    <= mem_a + 32'd1;
               mem_dout <= wdata_q[{next_cnt, 3'b000} +: 8];
            end
         end
      end
   end

endmodule
